spi_mode_sequencer: RTL and testbench
=====================================

# spi_mode_sequencer

Synthesizable, parametrised stimulus sequencer for the SPI master. It sweeps all four SPI modes (CKP/CPH), issuing a configurable number of START-triggered transactions per mode. Each transaction waits on the master's DONE with a timeout, and the sweep ends with an optional mid-transaction abort phase. It sits between the bench (or an on-chip self-test controller) and the SPI master's CKP, CPH, START and abort inputs.

## Interface
Parameters:
- REPS, 2: transactions per mode (≥1)
- GAP, 8: idle cycles between transactions (≥1)
- START_LEN, 3: cycles START is held high (≥1)
- SETUP, 2: cycles CKP/CPH are stable before START rises (≥1)
- TIMEOUT, 256: max cycles in WAIT_DONE before error
- ABORT_AT, 50: cycles after START falls before ABORT in the abort phase; 0 disables the abort phase
- ABORT_LEN, 10: cycles ABORT is held high
- CW, $clog2(4*REPS+2): TXN_COUNT width

Ports:
- CLOCK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- RUN  in  1  start a full sweep; sampled only in IDLE
- DONE  in  1  end-of-transaction pulse from SPI master
- CKP  out  1  clock polarity = MODE[1]
- CPH  out  1  clock phase = MODE[0]
- START  out  1  transaction request to SPI master
- ABORT  out  1  abort request to SPI master
- MODE  out  2  current mode 0..3
- BUSY  out  1  high from sweep accept until FINISHED
- TXN_COUNT  out  CW  completed transactions, DONE-terminated only
- ERROR  out  1  sticky; set on any timeout
- FINISHED  out  1  one-cycle pulse at end of sweep

## Operation
- Reset values: all outputs 0, state IDLE, internal counters 0.
- States: IDLE, SETUP, START_P, WAIT_DONE, GAP, ABORT_WAIT, ABORT_P, END.
- IDLE, RUN=1: MODE=0, BUSY=1, TXN_COUNT=0, ERROR=0, go to SETUP.
- SETUP: hold for SETUP cycles, then go to START_P.
- START_P: START=1 for START_LEN cycles, then go to WAIT_DONE.
- WAIT_DONE:
  - DONE=1: TXN_COUNT+1, go to GAP.
  - Wait counter reaches TIMEOUT with no DONE: set ERROR, pulse ABORT for 1 cycle, go to GAP. TXN_COUNT is not incremented.
- GAP: wait GAP cycles, then:
  - If fewer than REPS transactions are done in this mode: go to SETUP.
  - Else if MODE<3: MODE+1, go to SETUP.
  - Else if ABORT_AT>0: MODE=0, SETUP, START_P, then ABORT_WAIT.
  - Else: go to END.
- ABORT_WAIT: count ABORT_AT cycles, then go to ABORT_P.
  - A DONE arriving first counts as a transaction and skips ABORT_P; go to GAP.
- ABORT_P: ABORT=1 for ABORT_LEN cycles, then go to GAP. After that GAP, go to END.
- END: FINISHED=1 for 1 cycle, BUSY=0, go to IDLE.
- CKP/CPH/MODE change only on the GAP→SETUP or IDLE→SETUP transitions. They never change while START, ABORT or WAIT_DONE is active.
- DONE outside WAIT_DONE/ABORT_WAIT is ignored. RUN while BUSY is ignored.
- DONE in the same cycle the timeout is reached: DONE wins, no ERROR.
- RESET mid-sweep: all outputs return to reset values at the next edge; START and ABORT drop immediately.

## Timing
- RUN high at edge k: BUSY=1 and MODE=0 visible after edge k. START rises after edge k+SETUP and falls after edge k+SETUP+START_LEN.
- DONE at edge d: TXN_COUNT updates after edge d. The next START rises after edge d+GAP+SETUP.
- Timeout: ABORT pulse occurs at edge s+TIMEOUT, where s is the edge at which START falls.
- Full sweep, no timeouts, abort phase taken: TXN_COUNT ends at 4*REPS.

## Structure
- Shared package spi_pkg holds:
  - state enum
  - mode encoding constants MODE0..MODE3
  - function mode_to_ckp_cph
- One sub-module: spi_seq_timer, a loadable down-counter with a zero flag. It is reused for SETUP, START_LEN, GAP, TIMEOUT, ABORT_AT and ABORT_LEN.
- Top-level holds the FSM, mode register, rep counter, TXN_COUNT, and ERROR.

## Test plan
Defaults unless noted.
- Happy path: RUN pulse, DUT model returns DONE 20 cycles after START falls → MODE goes 0,1,2,3 with CKP/CPH = 00,01,10,11, two STARTs per mode each 3 cycles wide, TXN_COUNT=8, FINISHED pulse, ERROR=0.
- Abort phase: DONE withheld in the final transaction → ABORT high 10 cycles starting 50 cycles after START falls, MODE=0, TXN_COUNT stays 8.
- Timeout: DONE never returned in mode 1, TIMEOUT=16 → ERROR=1 after the first mode-1 transaction, 1-cycle ABORT, sweep continues, TXN_COUNT=6 at end.
- Simultaneous: DONE on the exact timeout cycle → TXN_COUNT increments, ERROR stays 0.
- Reset mid-operation: RESET during START_P in mode 2 → next cycle all outputs 0, state IDLE; new RUN restarts at MODE=0.
- Ignore rules: RUN pulses while BUSY and DONE during GAP → no extra START, TXN_COUNT unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI mode sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START_P,
    S_WAIT_DONE,
    S_GAP,
    S_ABORT_WAIT,
    S_ABORT_P,
    S_END
  } seqState_e;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  // SPI mode number maps to {CKP, CPH}: bit 1 is polarity, bit 0 is phase.
  function automatic logic [1:0] mode_to_ckp_cph(input logic [1:0] mode);
    return {mode[1], mode[0]};
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable down-counter with a zero flag, shared by every timed phase of the sequencer.
module spi_seq_timer #(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A load always wins; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/spi_mode_sequencer.sv
// Sweeps all four SPI modes, issuing START-triggered transactions to the SPI master,
// timing out on a missing DONE, and finishing with an optional mid-transaction abort.
module spi_mode_sequencer
  import spi_pkg::*;
#(
  parameter int REPS      = 2,
  parameter int GAP       = 8,
  parameter int START_LEN = 3,
  parameter int SETUP     = 2,
  parameter int TIMEOUT   = 256,
  parameter int ABORT_AT  = 50,
  parameter int ABORT_LEN = 10,
  parameter int CW        = $clog2(4*REPS+2)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          run_i,
  input  logic          done_i,
  output logic          ckp_o,
  output logic          cph_o,
  output logic          start_o,
  output logic          abort_o,
  output logic [1:0]    mode_o,
  output logic          busy_o,
  output logic [CW-1:0] txnCount_o,
  output logic          error_o,
  output logic          finished_o
);

  // The timer must hold the largest phase length minus one.
  localparam int MAX1 = (SETUP > START_LEN) ? SETUP : START_LEN;
  localparam int MAX2 = (MAX1 > GAP) ? MAX1 : GAP;
  localparam int MAX3 = (MAX2 > TIMEOUT) ? MAX2 : TIMEOUT;
  localparam int MAX4 = (MAX3 > ABORT_AT) ? MAX3 : ABORT_AT;
  localparam int MAXV = (MAX4 > ABORT_LEN) ? MAX4 : ABORT_LEN;
  localparam int TW   = $clog2(MAXV + 1);
  localparam int RW   = $clog2(REPS + 1);

  // A phase of N cycles loads N-1 so the zero flag marks its final cycle.
  localparam logic [TW-1:0] SETUP_LD     = TW'(SETUP - 1);
  localparam logic [TW-1:0] START_LD     = TW'(START_LEN - 1);
  localparam logic [TW-1:0] GAP_LD       = TW'(GAP - 1);
  localparam logic [TW-1:0] TIMEOUT_LD   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] ABORT_AT_LD  = TW'((ABORT_AT > 0) ? ABORT_AT - 1 : 0);
  localparam logic [TW-1:0] ABORT_LEN_LD = TW'(ABORT_LEN - 1);
  localparam logic [RW-1:0] REPS_V       = RW'(REPS);

  seqState_e     state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [RW-1:0] repCount_q, repCount_d;
  logic [CW-1:0] txnCount_q, txnCount_d;
  logic          error_q, error_d;
  logic          abortPulse_q, abortPulse_d;
  logic          abortPhase_q, abortPhase_d;

  logic          timerLoad;
  logic [TW-1:0] timerValue;
  logic          timerZero;

  spi_seq_timer #(
    .W(TW)
  ) u_timer (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (timerLoad),
    .value_i (timerValue),
    .zero_o  (timerZero)
  );

  // Next-state logic: each timed phase loads the timer on entry and exits on its zero flag.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    repCount_d   = repCount_q;
    txnCount_d   = txnCount_q;
    error_d      = error_q;
    abortPulse_d = 1'b0;
    abortPhase_d = abortPhase_q;
    timerLoad    = 1'b0;
    timerValue   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d      = S_SETUP;
          mode_d       = MODE0;
          repCount_d   = '0;
          txnCount_d   = '0;
          error_d      = 1'b0;
          abortPhase_d = 1'b0;
          timerLoad    = 1'b1;
          timerValue   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (timerZero) begin
          state_d    = S_START_P;
          timerLoad  = 1'b1;
          timerValue = START_LD;
        end
      end
      S_START_P: begin
        if (timerZero) begin
          timerLoad = 1'b1;
          if (abortPhase_q) begin
            state_d    = S_ABORT_WAIT;
            timerValue = ABORT_AT_LD;
          end else begin
            state_d    = S_WAIT_DONE;
            timerValue = TIMEOUT_LD;
          end
        end
      end
      S_WAIT_DONE: begin
        if (done_i) begin
          state_d    = S_GAP;
          txnCount_d = txnCount_q + CW'(1);
          repCount_d = repCount_q + RW'(1);
          timerLoad  = 1'b1;
          timerValue = GAP_LD;
        end else if (timerZero) begin
          state_d      = S_GAP;
          error_d      = 1'b1;
          abortPulse_d = 1'b1;
          repCount_d   = repCount_q + RW'(1);
          timerLoad    = 1'b1;
          timerValue   = GAP_LD;
        end
      end
      S_GAP: begin
        if (timerZero) begin
          if (abortPhase_q) begin
            state_d = S_END;
          end else if (repCount_q < REPS_V) begin
            state_d    = S_SETUP;
            timerLoad  = 1'b1;
            timerValue = SETUP_LD;
          end else if (mode_q != MODE3) begin
            state_d    = S_SETUP;
            mode_d     = mode_q + 2'd1;
            repCount_d = '0;
            timerLoad  = 1'b1;
            timerValue = SETUP_LD;
          end else if (ABORT_AT > 0) begin
            state_d      = S_SETUP;
            mode_d       = MODE0;
            abortPhase_d = 1'b1;
            timerLoad    = 1'b1;
            timerValue   = SETUP_LD;
          end else begin
            state_d = S_END;
          end
        end
      end
      S_ABORT_WAIT: begin
        if (done_i) begin
          state_d    = S_GAP;
          txnCount_d = txnCount_q + CW'(1);
          timerLoad  = 1'b1;
          timerValue = GAP_LD;
        end else if (timerZero) begin
          state_d    = S_ABORT_P;
          timerLoad  = 1'b1;
          timerValue = ABORT_LEN_LD;
        end
      end
      S_ABORT_P: begin
        if (timerZero) begin
          state_d    = S_GAP;
          timerLoad  = 1'b1;
          timerValue = GAP_LD;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE0;
      repCount_q   <= '0;
      txnCount_q   <= '0;
      error_q      <= 1'b0;
      abortPulse_q <= 1'b0;
      abortPhase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      repCount_q   <= repCount_d;
      txnCount_q   <= txnCount_d;
      error_q      <= error_d;
      abortPulse_q <= abortPulse_d;
      abortPhase_q <= abortPhase_d;
    end
  end

  // START and ABORT are gated by reset so the master sees them drop without waiting for an edge.
  assign start_o    = (state_q == S_START_P) && !reset_i;
  assign abort_o    = (abortPulse_q || (state_q == S_ABORT_P)) && !reset_i;
  assign busy_o     = (state_q != S_IDLE) && (state_q != S_END);
  assign finished_o = (state_q == S_END);
  assign mode_o     = mode_q;
  assign txnCount_o = txnCount_q;
  assign error_o    = error_q;
  assign {ckp_o, cph_o} = mode_to_ckp_cph(mode_q);

endmodule

// File: tb/tb_spi_mode_sequencer.sv
// Self-checking bench: a timeline model derived from the sequencer's timing rules
// predicts every output on every edge for two instances (default and short timeout).
module tb_spi_mode_sequencer;

  localparam int REPS      = 2;
  localparam int GAP       = 8;
  localparam int START_LEN = 3;
  localparam int SETUP     = 2;
  localparam int ABORT_AT  = 50;
  localparam int ABORT_LEN = 10;
  localparam int CW        = $clog2(4*REPS+2);
  localparam int NTXN      = 4*REPS + 1;
  localparam int MAXC      = 800;
  localparam int F_MODE    = 0;
  localparam int F_TXN     = 1;
  localparam int F_ERR     = 2;
  localparam int F_BUSY    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          runS    [2];
  logic          doneS   [2];
  logic          ckpS    [2];
  logic          cphS    [2];
  logic          startS  [2];
  logic          abortS  [2];
  logic [1:0]    modeS   [2];
  logic          busyS   [2];
  logic [CW-1:0] txnS    [2];
  logic          errS    [2];
  logic          finS    [2];

  bit expStart [MAXC];
  bit expAbort [MAXC];
  bit expFin   [MAXC];
  bit expBusy  [MAXC];
  bit expErr   [MAXC];
  int expMode  [MAXC];
  int expTxn   [MAXC];
  bit stimRun  [MAXC];
  bit stimDone [MAXC];
  bit stimReset[MAXC];
  int dly      [NTXN];
  int txnRise  [NTXN];
  int endEdge;
  int rEdge;
  int checks;
  int failures;

  spi_mode_sequencer #(
    .REPS(REPS), .GAP(GAP), .START_LEN(START_LEN), .SETUP(SETUP),
    .TIMEOUT(256), .ABORT_AT(ABORT_AT), .ABORT_LEN(ABORT_LEN), .CW(CW)
  ) dut0 (
    .clock_i(clock), .reset_i(reset), .run_i(runS[0]), .done_i(doneS[0]),
    .ckp_o(ckpS[0]), .cph_o(cphS[0]), .start_o(startS[0]), .abort_o(abortS[0]),
    .mode_o(modeS[0]), .busy_o(busyS[0]), .txnCount_o(txnS[0]),
    .error_o(errS[0]), .finished_o(finS[0])
  );

  spi_mode_sequencer #(
    .REPS(REPS), .GAP(GAP), .START_LEN(START_LEN), .SETUP(SETUP),
    .TIMEOUT(16), .ABORT_AT(ABORT_AT), .ABORT_LEN(ABORT_LEN), .CW(CW)
  ) dut1 (
    .clock_i(clock), .reset_i(reset), .run_i(runS[1]), .done_i(doneS[1]),
    .ckp_o(ckpS[1]), .cph_o(cphS[1]), .start_o(startS[1]), .abort_o(abortS[1]),
    .mode_o(modeS[1]), .busy_o(busyS[1]), .txnCount_o(txnS[1]),
    .error_o(errS[1]), .finished_o(finS[1])
  );

  always #5 clock = ~clock;

  // Wipe the model and the stimulus tables.
  task automatic clearModel();
    for (int n = 0; n < MAXC; n++) begin
      expStart[n] = 0; expAbort[n] = 0; expFin[n] = 0; expBusy[n] = 0;
      expErr[n] = 0; expMode[n] = 0; expTxn[n] = 0;
      stimRun[n] = 0; stimDone[n] = 0; stimReset[n] = 0;
    end
  endtask

  // A level-type output takes value v from edge n onward.
  task automatic setFrom(input int field, input int n, input int v);
    for (int i = n; i < MAXC; i++) begin
      case (field)
        F_MODE:  expMode[i] = v;
        F_TXN:   expTxn[i]  = v;
        F_ERR:   expErr[i]  = (v != 0);
        default: expBusy[i] = (v != 0);
      endcase
    end
  endtask

  // Synchronous reset sampled at edge n: everything reads zero afterwards.
  task automatic zeroFrom(input int n);
    for (int i = n; i < MAXC; i++) begin
      expStart[i] = 0; expAbort[i] = 0; expFin[i] = 0; expBusy[i] = 0;
      expErr[i] = 0; expMode[i] = 0; expTxn[i] = 0;
      stimRun[i] = 0; stimDone[i] = 0;
    end
    stimReset[n] = 1;
  endtask

  // Timeline of one sweep started by RUN at edge k; dly[i] is the DONE delay after START falls (0 = never).
  task automatic buildTimeline(input int k, input int to);
    int t, sr, sf, d, txn, idx;
    t = k;
    txn = 0;
    stimRun[k] = 1;
    setFrom(F_BUSY, k, 1);
    setFrom(F_ERR, k, 0);
    setFrom(F_TXN, k, 0);
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < REPS; r++) begin
        idx = m*REPS + r;
        setFrom(F_MODE, t, m);
        sr = t + SETUP;
        sf = sr + START_LEN;
        txnRise[idx] = sr;
        for (int i = sr; i < sf; i++) expStart[i] = 1;
        if (dly[idx] >= 1 && dly[idx] <= to) begin
          d = sf + dly[idx];
          stimDone[d] = 1;
          txn++;
          setFrom(F_TXN, d, txn);
          t = d + GAP;
        end else begin
          expAbort[sf + to] = 1;
          setFrom(F_ERR, sf + to, 1);
          t = sf + to + GAP;
        end
      end
    end
    idx = 4*REPS;
    setFrom(F_MODE, t, 0);
    sr = t + SETUP;
    sf = sr + START_LEN;
    txnRise[idx] = sr;
    for (int i = sr; i < sf; i++) expStart[i] = 1;
    if (dly[idx] >= 1 && dly[idx] <= ABORT_AT) begin
      d = sf + dly[idx];
      stimDone[d] = 1;
      txn++;
      setFrom(F_TXN, d, txn);
      t = d + GAP;
    end else begin
      for (int i = sf + ABORT_AT; i < sf + ABORT_AT + ABORT_LEN; i++) expAbort[i] = 1;
      t = sf + ABORT_AT + ABORT_LEN + GAP;
    end
    expFin[t] = 1;
    setFrom(F_BUSY, t, 0);
    endEdge = t;
  endtask

  // Pin the model against a hand-computed value.
  task automatic checkLit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: model gives %0d, hand value %0d", name, got, want);
    end
  endtask

  // Drive the inputs that the DUT will sample at edge n.
  task automatic applyStimulus(input int inst, input int n);
    reset = (n < 2) || stimReset[n];
    runS[inst] = stimRun[n];
    doneS[inst] = stimDone[n];
    runS[1-inst] = 1'b0;
    doneS[1-inst] = 1'b0;
    if (stimReset[n]) begin
      #1;
      checks++;
      if (startS[inst] !== 1'b0 || abortS[inst] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_drop edge %0d: start=%b abort=%b, expected both 0",
                 n, startS[inst], abortS[inst]);
      end
    end
  endtask

  // Compare every output of the active instance with the model after edge n.
  task automatic checkOutput(input int inst, input int n, input string name);
    logic [1:0]    em;
    logic [CW-1:0] et;
    logic [CW+8:0] got, want;
    em = expMode[n][1:0];
    et = expTxn[n][CW-1:0];
    want = {em[1], em[0], expStart[n], expAbort[n], em, expBusy[n], et, expErr[n], expFin[n]};
    got  = {ckpS[inst], cphS[inst], startS[inst], abortS[inst], modeS[inst], busyS[inst],
            txnS[inst], errS[inst], finS[inst]};
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s edge %0d: got ckp=%b cph=%b start=%b abort=%b mode=%0d busy=%b txn=%0d err=%b fin=%b; expected ckp=%b cph=%b start=%b abort=%b mode=%0d busy=%b txn=%0d err=%b fin=%b",
               name, n, ckpS[inst], cphS[inst], startS[inst], abortS[inst], modeS[inst],
               busyS[inst], txnS[inst], errS[inst], finS[inst], em[1], em[0], expStart[n],
               expAbort[n], em, expBusy[n], et, expErr[n], expFin[n]);
    end
  endtask

  task automatic runScenario(input int inst, input string name, input int lastEdge);
    for (int n = 0; n <= lastEdge; n++) begin
      applyStimulus(inst, n);
      @(posedge clock);
      @(negedge clock);
      checkOutput(inst, n, name);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    runS[0] = 1'b0; runS[1] = 1'b0; doneS[0] = 1'b0; doneS[1] = 1'b0;

    // Happy path with abort phase; stray RUN and DONE pulses sprinkled in.
    clearModel();
    for (int i = 0; i < NTXN-1; i++) dly[i] = 20;
    dly[NTXN-1] = 0;
    buildTimeline(4, 256);
    stimRun[14] = 1;
    stimRun[txnRise[3]] = 1;
    stimRun[txnRise[6] + 1] = 1;
    stimDone[32] = 1;
    stimDone[txnRise[1] + 1] = 1;
    checkLit("happy_start5", expStart[5], 0);
    checkLit("happy_start6", expStart[6], 1);
    checkLit("happy_start9", expStart[9], 0);
    checkLit("happy_txn28", expTxn[28], 0);
    checkLit("happy_txn29", expTxn[29], 1);
    checkLit("happy_rise1", txnRise[1], 39);
    checkLit("happy_mode70", expMode[70], 1);
    checkLit("happy_abort322", expAbort[322], 0);
    checkLit("happy_abort323", expAbort[323], 1);
    checkLit("happy_abort332", expAbort[332], 1);
    checkLit("happy_abort333", expAbort[333], 0);
    checkLit("happy_end", endEdge, 341);
    checkLit("happy_txn_end", expTxn[341], 8);
    runScenario(0, "happy", endEdge + 4);

    // Short timeout, no DONE in mode 1.
    clearModel();
    for (int i = 0; i < NTXN-1; i++) dly[i] = 10;
    dly[2] = 0;
    dly[3] = 0;
    dly[NTXN-1] = 0;
    buildTimeline(4, 16);
    checkLit("tmo_abort71", expAbort[71], 1);
    checkLit("tmo_abort72", expAbort[72], 0);
    checkLit("tmo_err70", expErr[70], 0);
    checkLit("tmo_err71", expErr[71], 1);
    checkLit("tmo_end", endEdge, 273);
    checkLit("tmo_txn_end", expTxn[273], 6);
    runScenario(1, "timeout", endEdge + 4);

    // DONE on the exact timeout cycle, then DONE before the abort point.
    clearModel();
    for (int i = 0; i < NTXN-1; i++) dly[i] = 5;
    dly[0] = 16;
    dly[NTXN-1] = 30;
    buildTimeline(4, 16);
    checkLit("sim_txn25", expTxn[25], 1);
    checkLit("sim_err25", expErr[25], 0);
    checkLit("sim_abort214", expAbort[214], 0);
    checkLit("sim_end", endEdge, 202);
    checkLit("sim_txn_end", expTxn[202], 9);
    runScenario(1, "simultaneous", endEdge + 4);

    // Reset while START is high in mode 2, then a fresh sweep.
    clearModel();
    for (int i = 0; i < NTXN-1; i++) dly[i] = 20;
    dly[NTXN-1] = 0;
    buildTimeline(4, 256);
    checkLit("rst_rise4", txnRise[4], 138);
    checkLit("rst_mode138", expMode[138], 2);
    rEdge = txnRise[4] + 1;
    zeroFrom(rEdge);
    checkLit("rst_mode139", expMode[139], 0);
    buildTimeline(rEdge + 3, 256);
    runScenario(0, "reset_mid", endEdge + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
